// File: rtl/ps2_kbd_rx.sv
// ----------------------------------------------------------------------------
// ps2_kbd_rx
//
// PS/2 keyboard receiver. Both raw pins are synchronized into the clk domain,
// the PS/2 clock is glitch-filtered, and every filtered falling edge samples
// one bit of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
// Valid bytes are decoded into key events. E0/F0 prefixes, the E1 pause
// sequence, keyboard status bytes and fake-shift codes are consumed here and
// never produce an event.
//
// Ports
//   clk         system clock, all logic on its rising edge
//   reset       synchronous, active-high reset
//   ps2_clk_i   raw PS/2 clock pin (asynchronous)
//   ps2_data_i  raw PS/2 data pin (asynchronous)
//   ps2_key     [10] toggles once per event, [9] pressed, [8] E0-extended,
//               [7:0] scan code; holds between events
//   frame_err   one-cycle pulse on a parity or stop-bit error
//
// Parameters
//   FILTER_LEN      equal synchronized samples needed to move the filtered clock
//   TIMEOUT_CYCLES  idle clk cycles mid-frame before the frame is abandoned
// ----------------------------------------------------------------------------
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // --------------------------------------------------------------------------
  // Synchronizers: both pins idle high, so reset them to 1.
  // --------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_s;
  logic       data_s;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // --------------------------------------------------------------------------
  // Glitch filter. The counter tracks how many consecutive samples disagree
  // with the filtered level; on the FILTER_LEN-th such sample the level flips.
  // Any agreeing sample restarts the count, so short pulses vanish.
  // --------------------------------------------------------------------------
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           filt_clk_q, filt_clk_d;
  logic           fall;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_s != filt_clk_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // One-cycle strobe in the cycle the filtered clock goes low; data_s is
  // sampled in that same cycle, so each edge yields exactly one bit.
  assign fall = filt_clk_q & ~filt_clk_d;

  // --------------------------------------------------------------------------
  // Frame FSM: state register / next state / outputs.
  // --------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout;

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive cycle without an edge.
  assign timeout = (state_q != ST_IDLE) && !fall &&
                   (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE:   if (!data_s) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  logic start_bit;
  logic shift_en;
  logic par_en;
  logic stop_en;

  always_comb begin
    start_bit = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    if (fall) begin
      unique case (state_q)
        ST_IDLE:   start_bit = !data_s;
        ST_DATA:   shift_en  = 1'b1;
        ST_PARITY: par_en    = 1'b1;
        ST_STOP:   stop_en   = 1'b1;
        default:   ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bit collection and frame check.
  // --------------------------------------------------------------------------
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       frame_ok;
  logic       frame_bad;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    if (start_bit) begin
      bit_cnt_d = 3'd0;
    end else if (shift_en) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {data_s, shift_q[7:1]};  // LSB arrives first
    end
    if (par_en) begin
      parity_d = data_s;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (state_q == ST_IDLE || fall || timeout) begin
      to_cnt_d = '0;
    end
  end

  // Odd parity over data+parity, and the stop bit (sampled now) must be 1.
  assign frame_ok  = stop_en && data_s && (^{shift_q, parity_q});
  assign frame_bad = stop_en && !frame_ok;

  // --------------------------------------------------------------------------
  // Byte decode.
  // --------------------------------------------------------------------------
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;
  logic [2:0]  skip_q, skip_d;
  logic [10:0] key_q, key_d;
  logic        frame_err_q, frame_err_d;

  // Keyboard replies and status codes that carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  always_comb begin
    ext_d       = ext_q;
    rel_d       = rel_q;
    skip_d      = skip_q;
    key_d       = key_q;
    frame_err_d = 1'b0;
    if (timeout) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (frame_bad) begin
      // Skip count is left alone: only valid bytes advance the pause skip.
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      rel_d       = 1'b0;
    end else if (frame_ok) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (shift_q == 8'hE1) begin
        // Pause: E1 plus the next 7 valid bytes are swallowed.
        skip_d = 3'd7;
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        rel_d = 1'b1;
      end else if (is_status(shift_q)) begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end else if (ext_q && (shift_q == 8'h12 || shift_q == 8'h59)) begin
        // E0-prefixed shift codes are fake shifts emitted around nav keys.
        ext_d = 1'b0;
        rel_d = 1'b0;
      end else begin
        key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_q  <= '0;
      filt_clk_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      to_cnt_q    <= '0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= 3'd0;
      key_q       <= 11'd0;
      frame_err_q <= 1'b0;
    end else begin
      filt_cnt_q  <= filt_cnt_d;
      filt_clk_q  <= filt_clk_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      key_q       <= key_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILTER_LEN, 8: consecutive equal synchronized samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYCLES, 65535: clk cycles without a filtered falling edge, mid-frame, before the frame is aborted.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk_i  input  1  raw PS/2 clock pin, asynchronous to clk.
REQ-006 ps2_data_i  input  1  raw PS/2 data pin, asynchronous to clk.
REQ-007 ps2_key  output  11  key event: [10] toggle strobe, [9] pressed (1) / released (0), [8] E0-extended, [7:0] scan code.
REQ-008 frame_err  output  1  one-cycle pulse on a parity or stop-bit error.

Function
REQ-009 Both pins SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Glitch filter: the filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; shorter pulses SHALL be ignored.
REQ-011 On each filtered-clock falling edge the synchronized data SHALL be sampled exactly once.
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay IDLE.
- DATA: shift data LSB first; after the 8th bit -> PARITY.
- PARITY: store the bit -> STOP.
- STOP: -> IDLE.
REQ-013 Frame validity: frame valid only if data plus parity has an odd number of ones and the stop bit is 1; otherwise pulse frame_err for one cycle, discard the byte, clear the prefix flags.
REQ-014 Timeout: in DATA, PARITY or STOP, TIMEOUT_CYCLES clk cycles without a falling edge SHALL force IDLE, discard the partial byte and clear the prefix flags; frame_err SHALL not pulse.
REQ-015 Valid byte decode, in priority order:
- E1 -> discard this byte and the next 7 valid bytes (pause sequence), with no events.
- E0 -> set the ext flag.
- F0 -> set the rel flag.
- FA, AA, EE, FE, 00, FF -> discard and clear the flags.
- 12 or 59 with ext flag set -> discard (fake shift) and clear the flags.
- Any other byte -> key event.
REQ-016 Key event: ps2_key[7:0] = byte, [8] = ext, [9] = ~rel, [10] inverted; flags cleared; all in one clk edge.
REQ-017 Latency: ps2_key SHALL update on the clk edge following the cycle in which the stop-bit falling edge is detected.
REQ-018 ps2_key[9:0] SHALL hold between events; ps2_key[10] SHALL toggle exactly once per event.
REQ-019 Prefix flags SHALL persist across byte boundaries until consumed or cleared; repeated E0 or F0 leaves the flag set.
REQ-020 The pause-skip counter SHALL count valid bytes only; an errored frame inside the skip SHALL not decrement it.

Reset
REQ-021 During reset the following SHALL be forced on the same clk edge:
- ps2_key = 0, frame_err = 0.
- FSM to IDLE; flags, skip count, bit count and timeout counter cleared.
- Synchronizer and filtered clock to 1 (bus idle).
REQ-022 Reset mid-frame SHALL discard the partial frame with no event and no frame_err; the first complete frame after reset release SHALL decode normally.

Verification
REQ-023 Bench SHALL cover the following scenarios:
- Frame 1C with parity 0 -> ps2_key = {~old[10], 1, 0, 8'h1C}, exactly one toggle, frame_err stays 0.
- Frames F0, 1C -> one event with [9] = 0, [8] = 0, [7:0] = 1C; no event on the F0 byte.
- Frames E0, F0, 75 -> one event with [9] = 0, [8] = 1, [7:0] = 75; then frame 1C -> [8] = 0, [9] = 1.
- Frame 1C with parity 1 -> frame_err high exactly one cycle, no toggle; next valid 1C -> normal event.
- 5 bits sent, then clock idle for TIMEOUT_CYCLES + 10 -> no event, no frame_err; next valid 1C decodes. A clock glitch of FILTER_LEN - 1 cycles mid-frame -> no extra bit.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> zero events; E0 12 -> zero events; reset asserted mid-frame -> ps2_key = 0.
